cd: RTL and testbench

Configurable clock/tick generator for the display/UART subsystem. From the single system clock `clk` it derives four registered, square-wave enable clocks: `clk_VGA` (from the external pixel reference `clkinVGA`), `clk_UART`, `clk_LM` and `clk_DB`. Two of these rates can be reprogrammed at run time through a small valid/ready register-write port.

---
 rtl/cd.sv | 216 +++++++++++++++++++++
 tb/tb_cd.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cd.sv
// cd : clock/tick generator for the display/UART subsystem.
//
// Derives four registered square-wave enable clocks from the system clock:
//   clk_VGA  - synchronized external pixel reference, passed through or
//              divided by 2/4/8 (vga_sel)
//   clk_UART - UART_HALF_BASE >> uart_sel half-period divider
//   clk_LM   - fixed LM_HALF half-period divider
//   clk_DB   - fixed DB_HALF half-period divider
// uart_sel and vga_sel are written through a valid/ready config port.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   clkinVGA  in   asynchronous VGA reference
//   c_valid   in   config write request
//   c_addr    in   [3:0] config address (4'b0100 uart_sel, 4'b1000 vga_sel)
//   c_data    in   [7:0] config data
//   c_ready   out  config port ready (1 from the first cycle after reset)
//   clk_VGA, clk_UART, clk_LM, clk_DB  out  generated clocks
module cd #(
  parameter int unsigned UART_HALF_BASE = 1302,
  parameter int unsigned LM_HALF        = 2500,
  parameter int unsigned DB_HALF        = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkinVGA,
  input  logic       c_valid,
  input  logic [3:0] c_addr,
  input  logic [7:0] c_data,
  output logic       c_ready,
  output logic       clk_VGA,
  output logic       clk_UART,
  output logic       clk_LM,
  output logic       clk_DB
);

  localparam int unsigned UART_W = $clog2(UART_HALF_BASE + 1);
  localparam int unsigned LM_W   = $clog2(LM_HALF + 1);
  localparam int unsigned DB_W   = $clog2(DB_HALF + 1);

  localparam logic [3:0] ADDR_UART = 4'b0100;
  localparam logic [3:0] ADDR_VGA  = 4'b1000;

  localparam logic [UART_W-1:0] UART_ONE = UART_W'(32'd1);
  localparam logic [LM_W-1:0]   LM_LAST  = LM_W'(LM_HALF - 32'd1);
  localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_HALF - 32'd1);

  // Config port
  logic c_ready_q, c_ready_d;
  logic uart_wr_s, vga_wr_s;
  logic unused_data_s;

  // UART divider
  logic [2:0]        uart_sel_q, uart_sel_d;
  logic [UART_W-1:0] uart_cnt_q, uart_cnt_d;
  logic [UART_W-1:0] uart_half_s, uart_last_s;
  logic              clk_uart_q, clk_uart_d;

  // VGA path
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic       sync3_q, sync3_d;
  logic       vga_rise_q, vga_rise_d;
  logic [1:0] vga_sel_q, vga_sel_d;
  logic [1:0] vga_cnt_q, vga_cnt_d;
  logic [1:0] vga_last_s;
  logic       clk_vga_q, clk_vga_d;

  // Fixed dividers
  logic [LM_W-1:0] lm_cnt_q, lm_cnt_d;
  logic            clk_lm_q, clk_lm_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            clk_db_q, clk_db_d;

  assign uart_wr_s     = c_valid && c_ready_q && (c_addr == ADDR_UART);
  assign vga_wr_s      = c_valid && c_ready_q && (c_addr == ADDR_VGA);
  assign unused_data_s = ^c_data[7:3];

  // Ready rises one cycle after reset and stays high (no back-pressure)
  always_comb begin
    c_ready_d = 1'b1;
  end

  // UART half-period; large selects would shift to zero, so hold at one
  always_comb begin
    uart_half_s = UART_W'(UART_HALF_BASE) >> uart_sel_q;
    if (uart_half_s == '0) begin
      uart_half_s = UART_ONE;
    end else begin
      uart_half_s = uart_half_s;
    end
    uart_last_s = uart_half_s - UART_ONE;
  end

  // UART divider: a changed select clears the count and holds the level
  always_comb begin
    uart_sel_d = uart_sel_q;
    uart_cnt_d = uart_cnt_q;
    clk_uart_d = clk_uart_q;
    if (uart_wr_s && (c_data[2:0] != uart_sel_q)) begin
      uart_sel_d = c_data[2:0];
      uart_cnt_d = '0;
    end else if (uart_cnt_q == uart_last_s) begin
      uart_cnt_d = '0;
      clk_uart_d = ~clk_uart_q;
    end else begin
      uart_cnt_d = uart_cnt_q + UART_ONE;
    end
  end

  // Synchronizer, delayed copy and registered rising-edge pulse
  always_comb begin
    sync1_d    = clkinVGA;
    sync2_d    = sync1_q;
    sync3_d    = sync2_q;
    vga_rise_d = sync2_q & ~sync3_q;
  end

  // Number of synchronized rises between clk_VGA toggles, minus one
  always_comb begin
    case (vga_sel_q)
      2'b01:   vga_last_s = 2'd0;
      2'b10:   vga_last_s = 2'd1;
      2'b11:   vga_last_s = 2'd3;
      default: vga_last_s = 2'd0;
    endcase
  end

  // VGA output: passthrough in mode 00, otherwise toggle on counted rises
  always_comb begin
    vga_sel_d = vga_sel_q;
    vga_cnt_d = vga_cnt_q;
    clk_vga_d = clk_vga_q;
    if (vga_wr_s && (c_data[1:0] != vga_sel_q)) begin
      vga_sel_d = c_data[1:0];
      vga_cnt_d = 2'd0;
    end else if (vga_sel_q == 2'b00) begin
      vga_cnt_d = 2'd0;
      clk_vga_d = sync2_q;
    end else if (vga_rise_q) begin
      if (vga_cnt_q == vga_last_s) begin
        vga_cnt_d = 2'd0;
        clk_vga_d = ~clk_vga_q;
      end else begin
        vga_cnt_d = vga_cnt_q + 2'd1;
      end
    end else begin
      vga_cnt_d = vga_cnt_q;
    end
  end

  // Free-running LED-matrix and debounce dividers
  always_comb begin
    lm_cnt_d = lm_cnt_q;
    clk_lm_d = clk_lm_q;
    db_cnt_d = db_cnt_q;
    clk_db_d = clk_db_q;
    if (lm_cnt_q == LM_LAST) begin
      lm_cnt_d = '0;
      clk_lm_d = ~clk_lm_q;
    end else begin
      lm_cnt_d = lm_cnt_q + LM_W'(32'd1);
    end
    if (db_cnt_q == DB_LAST) begin
      db_cnt_d = '0;
      clk_db_d = ~clk_db_q;
    end else begin
      db_cnt_d = db_cnt_q + DB_W'(32'd1);
    end
  end

  // State registers; reset wins over any simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      c_ready_q  <= 1'b0;
      uart_sel_q <= 3'd0;
      uart_cnt_q <= '0;
      clk_uart_q <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      sync3_q    <= 1'b0;
      vga_rise_q <= 1'b0;
      vga_sel_q  <= 2'd0;
      vga_cnt_q  <= 2'd0;
      clk_vga_q  <= 1'b0;
      lm_cnt_q   <= '0;
      clk_lm_q   <= 1'b0;
      db_cnt_q   <= '0;
      clk_db_q   <= 1'b0;
    end else begin
      c_ready_q  <= c_ready_d;
      uart_sel_q <= uart_sel_d;
      uart_cnt_q <= uart_cnt_d;
      clk_uart_q <= clk_uart_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sync3_q    <= sync3_d;
      vga_rise_q <= vga_rise_d;
      vga_sel_q  <= vga_sel_d;
      vga_cnt_q  <= vga_cnt_d;
      clk_vga_q  <= clk_vga_d;
      lm_cnt_q   <= lm_cnt_d;
      clk_lm_q   <= clk_lm_d;
      db_cnt_q   <= db_cnt_d;
      clk_db_q   <= clk_db_d;
    end
  end

  assign c_ready  = c_ready_q;
  assign clk_VGA  = clk_vga_q;
  assign clk_UART = clk_uart_q;
  assign clk_LM   = clk_lm_q;
  assign clk_DB   = clk_db_q;

endmodule

// File: tb/tb_cd.sv
// tb_cd : self-checking bench for cd.
// UART/LM/DB levels are predicted from elapsed-cycle arithmetic per segment
// (level = start_level ^ ((cycles / half) mod 2)); VGA is checked by
// measured periods and edge lag against the driven reference.
module tb_cd;

  localparam int UART_BASE = 16;
  localparam int LM_H      = 5;
  localparam int DB_H      = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkinVGA = 1'b0;
  logic       c_valid = 1'b0;
  logic [3:0] c_addr = 4'd0;
  logic [7:0] c_data = 8'd0;
  logic       c_ready, clk_VGA, clk_UART, clk_LM, clk_DB;

  cd #(.UART_HALF_BASE(UART_BASE), .LM_HALF(LM_H), .DB_HALF(DB_H)) dut (
    .clk(clk), .rst(rst), .clkinVGA(clkinVGA), .c_valid(c_valid),
    .c_addr(c_addr), .c_data(c_data), .c_ready(c_ready), .clk_VGA(clk_VGA),
    .clk_UART(clk_UART), .clk_LM(clk_LM), .clk_DB(clk_DB)
  );

  // 4 ns system clock, 312 ns VGA reference period
  always #2 clk = ~clk;
  always #156 clkinVGA = ~clkinVGA;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model state
  int   cyc = 0;       // edges since time zero
  int   n = 0;         // edges since last reset release
  bit   rdy_m = 1'b0;
  logic [2:0] u_sel = 3'd0;
  int   u_start = 0;
  bit   u_lvl0 = 1'b0;

  // VGA edge bookkeeping
  bit in_prev = 1'b0, vga_prev = 1'b0;
  int in_rise_cyc = 0, vga_rise_cyc = 0, vga_prev_rise = 0, vga_rises = 0;

  function automatic bit uart_model(input int k);
    int h;
    h = 32'd16 >> u_sel;
    if (h == 0) h = 1;
    return u_lvl0 ^ ((((k - u_start) / h) % 2) == 1);
  endfunction

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock edge: advance the model, then compare every modelled output
  task automatic step();
    bit rst_s, wr_s;
    logic [3:0] a_s;
    logic [7:0] d_s;
    rst_s = rst;
    wr_s  = c_valid && rdy_m;
    a_s   = c_addr;
    d_s   = c_data;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_s) begin
      n = 0; rdy_m = 1'b0; u_sel = 3'd0; u_start = 0; u_lvl0 = 1'b0;
    end else begin
      n++;
      if (wr_s && a_s == 4'b0100 && d_s[2:0] != u_sel) begin
        u_lvl0  = uart_model(n - 1);
        u_start = n;
        u_sel   = d_s[2:0];
      end
      rdy_m = 1'b1;
    end
    check("c_ready", c_ready, rdy_m);
    check("clk_UART", clk_UART, uart_model(n));
    check("clk_LM", clk_LM, ((n / LM_H) % 2) == 1);
    check("clk_DB", clk_DB, ((n / DB_H) % 2) == 1);
    if (rst_s) check("clk_VGA_rst", clk_VGA, 1'b0);
    if (clkinVGA && !in_prev) in_rise_cyc = cyc;
    if (clk_VGA && !vga_prev) begin
      vga_prev_rise = vga_rise_cyc;
      vga_rise_cyc  = cyc;
      vga_rises++;
    end
    in_prev  = clkinVGA;
    vga_prev = clk_VGA;
  endtask

  task automatic write(input logic [3:0] a, input logic [7:0] d);
    c_valid = 1'b1; c_addr = a; c_data = d;
    step();
    c_valid = 1'b0; c_addr = 4'd0; c_data = 8'd0;
  endtask

  // Rise-to-rise distance of clk_UART, bounded
  task automatic uart_period(output int p);
    bit prev;
    int r0, rises;
    prev = clk_UART; r0 = 0; rises = 0; p = -1;
    for (int i = 0; i < 200 && rises < 2; i++) begin
      step();
      if (clk_UART && !prev) begin
        rises++;
        if (rises == 1) r0 = cyc;
        else p = cyc - r0;
      end
      prev = clk_UART;
    end
  endtask

  task automatic wait_vga_rises(input int k, input string tag);
    int target;
    target = vga_rises + k;
    for (int i = 0; i < 3000 && vga_rises < target; i++) step();
    check({tag, "_reached"}, vga_rises >= target, 1'b1);
  endtask

  initial begin
    int p, lag;
    logic [3:0] a;
    logic [7:0] d;

    // Reset for two cycles
    rst = 1'b1;
    step();
    step();
    check("vga_in_reset", clk_VGA, 1'b0);
    rst = 1'b0;

    // First UART rise after 16 edges
    repeat (15) step();
    check("uart_before_first_rise", clk_UART, 1'b0);
    step();
    check("uart_first_rise", clk_UART, 1'b1);
    uart_period(p);
    check_int("uart_period_sel0", p, 32);

    // Select 4 held for 78 cycles
    c_valid = 1'b1; c_addr = 4'b0100; c_data = 8'h04;
    repeat (78) step();
    c_valid = 1'b0; c_addr = 4'd0; c_data = 8'd0;
    uart_period(p);
    check_int("uart_period_sel4", p, 2);

    write(4'b0100, 8'h02);
    uart_period(p);
    check_int("uart_period_sel2", p, 8);
    write(4'b0100, 8'h00);
    uart_period(p);
    check_int("uart_period_sel0_back", p, 32);

    // Ignored address
    write(4'b0001, 8'hFF);
    uart_period(p);
    check_int("uart_period_after_ignored", p, 32);

    // VGA passthrough
    wait_vga_rises(3, "vga00");
    check_int("vga00_period", vga_rise_cyc - vga_prev_rise, 78);
    lag = vga_rise_cyc - in_rise_cyc;
    check("vga00_lag_2_to_3", (lag >= 2) && (lag <= 3), 1'b1);

    // VGA /4
    write(4'b1000, 8'h02);
    wait_vga_rises(3, "vga10");
    check_int("vga10_period", vga_rise_cyc - vga_prev_rise, 312);
    lag = vga_rise_cyc - in_rise_cyc;
    check("vga10_lag_3_to_4", (lag >= 3) && (lag <= 4), 1'b1);

    // Back to passthrough
    write(4'b1000, 8'h00);
    wait_vga_rises(3, "vga00_back");
    check_int("vga00_back_period", vga_rise_cyc - vga_prev_rise, 78);

    // Randomized config traffic checked cycle by cycle against the model
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(3, 0))
        0: a = 4'b0100;
        1: a = 4'b1000;
        2: a = 4'b0001;
        default: a = 4'($urandom_range(15, 0));
      endcase
      d = 8'($urandom);
      if (a == 4'b0100) d[2:0] = 3'($urandom_range(4, 0));
      c_valid = ($urandom_range(3, 0) == 0);
      c_addr  = a;
      c_data  = d;
      step();
    end
    c_valid = 1'b0; c_addr = 4'd0; c_data = 8'd0;

    // Mid-run reset
    repeat (3) step();
    rst = 1'b1;
    step();
    check("rst_mid_uart", clk_UART, 1'b0);
    check("rst_mid_lm", clk_LM, 1'b0);
    check("rst_mid_db", clk_DB, 1'b0);
    check("rst_mid_ready", c_ready, 1'b0);
    rst = 1'b0;
    repeat (40) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
